// File: rtl/xbar_cfg_loader.sv
// Crossbar configuration loader. Select words are streamed into a shadow
// register one output at a time. The finished set is copied to the active
// crossbar configuration in a single COMMIT cycle, so the crossbar never
// sees a partially loaded configuration.
module xbar_cfg_loader #(
    parameter int NUM_IN  = 39,
    parameter int NUM_OUT = 54,
    parameter int SEL_W   = 6,
    localparam int CNT_W  = $clog2(NUM_OUT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_cfg_start,
    input  logic                     io_cfg_valid,
    input  logic [SEL_W-1:0]         io_cfg_sel,
    output logic                     io_cfg_ready,
    output logic                     io_cfg_done,
    output logic                     io_cfg_err,
    output logic                     io_busy,
    output logic [CNT_W-1:0]         io_load_count,
    output logic [NUM_OUT*SEL_W-1:0] io_mux_configs
);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t                         state_q, state_d;
    logic [NUM_OUT-1:0][SEL_W-1:0]  shadow_q;
    logic [NUM_OUT-1:0][SEL_W-1:0]  mux_q;
    logic [CNT_W-1:0]               count_q;
    logic                           done_q;
    logic                           err_q;

    logic                           accept;
    logic                           sel_oor;
    logic                           last_word;
    logic [SEL_W-1:0]               sel_clean;

    // A start in LOAD is an abort, so it blocks acceptance of that cycle's word.
    assign accept    = (state_q == LOAD) && io_cfg_valid && !io_cfg_start;
    assign sel_oor   = {1'b0, io_cfg_sel} >= (SEL_W+1)'(NUM_IN);
    assign sel_clean = sel_oor ? '0 : io_cfg_sel;
    assign last_word = (count_q == CNT_W'(NUM_OUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io_cfg_start) state_d = LOAD;
            LOAD:    if (accept && last_word) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One write-enabled shadow field per crossbar output, selected by the word count.
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_shadow
        always_ff @(posedge clk) begin
            if (reset)
                shadow_q[g] <= '0;
            else if (accept && (count_q == CNT_W'(g)))
                shadow_q[g] <= sel_clean;
        end
    end

    // Sequence bookkeeping: word count, sticky error, commit of the shadow and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            mux_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == COMMIT) begin
                mux_q  <= shadow_q;
                done_q <= 1'b1;
            end else if (io_cfg_start) begin
                // Fresh start from IDLE or abort-and-restart in LOAD.
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (accept) begin
                count_q <= count_q + CNT_W'(1);
                if (sel_oor) err_q <= 1'b1;
            end
        end
    end

    assign io_cfg_ready   = (state_q == LOAD);
    assign io_busy        = (state_q != IDLE);
    assign io_cfg_done    = done_q;
    assign io_cfg_err     = err_q;
    assign io_load_count  = count_q;
    assign io_mux_configs = mux_q;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Self-checking bench for xbar_cfg_loader: directed scenarios plus a random
// phase, all checked every cycle against a transaction-level reference model.
module tb_xbar_cfg_loader;

    localparam int NUM_IN  = 39;
    localparam int NUM_OUT = 54;
    localparam int SEL_W   = 6;
    localparam int CNT_W   = $clog2(NUM_OUT + 1);
    localparam int CFG_W   = NUM_OUT * SEL_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               io_cfg_start;
    logic               io_cfg_valid;
    logic [SEL_W-1:0]   io_cfg_sel;
    logic               io_cfg_ready;
    logic               io_cfg_done;
    logic               io_cfg_err;
    logic               io_busy;
    logic [CNT_W-1:0]   io_load_count;
    logic [CFG_W-1:0]   io_mux_configs;

    xbar_cfg_loader #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_cfg_start   (io_cfg_start),
        .io_cfg_valid   (io_cfg_valid),
        .io_cfg_sel     (io_cfg_sel),
        .io_cfg_ready   (io_cfg_ready),
        .io_cfg_done    (io_cfg_done),
        .io_cfg_err     (io_cfg_err),
        .io_busy        (io_busy),
        .io_load_count  (io_load_count),
        .io_mux_configs (io_mux_configs)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a sequence is either being collected, waiting one cycle
    // to be committed, or absent. Words land in a list indexed by arrival order.
    bit         m_collecting, m_committing, m_done, m_err;
    int         m_cnt;
    int         m_shadow [NUM_OUT];
    int         m_active [NUM_OUT];

    int         cyc = 0;
    int         n_done = 0;
    int         n_acc = 0;
    int         last_acc = -1;
    int         done_cyc = -1;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [CFG_W-1:0] model_cfg();
        logic [CFG_W-1:0] v;
        for (int i = 0; i < NUM_OUT; i++) v[i*SEL_W +: SEL_W] = SEL_W'(m_active[i]);
        return v;
    endfunction

    task automatic model_step(input bit st, input bit v, input int sel, input bit r);
        if (r) begin
            m_collecting = 0; m_committing = 0; m_done = 0; m_err = 0; m_cnt = 0;
            for (int i = 0; i < NUM_OUT; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
            return;
        end
        m_done = m_committing;
        if (m_committing) begin
            m_active = m_shadow;
            m_committing = 0;
        end else if (st) begin
            m_collecting = 1; m_cnt = 0; m_err = 0;
        end else if (m_collecting && v) begin
            m_shadow[m_cnt] = (sel >= NUM_IN) ? 0 : sel;
            if (sel >= NUM_IN) m_err = 1;
            m_cnt++;
            if (m_cnt == NUM_OUT) begin m_collecting = 0; m_committing = 1; end
        end
    endtask

    task automatic check_all();
        chk("ready", 512'(io_cfg_ready), 512'(m_collecting));
        chk("busy",  512'(io_busy),      512'(m_collecting || m_committing));
        chk("done",  512'(io_cfg_done),  512'(m_done));
        chk("err",   512'(io_cfg_err),   512'(m_err));
        chk("count", 512'(io_load_count), 512'(m_cnt));
        chk("cfg",   512'(io_mux_configs), 512'(model_cfg()));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic tick(input bit st, input bit v, input int sel, input bit r);
        io_cfg_start = st; io_cfg_valid = v; io_cfg_sel = SEL_W'(sel); reset = r;
        if (!r && m_collecting && v && !st) begin
            last_acc = cyc;
            n_acc++;
        end
        @(posedge clk);
        model_step(st, v, sel, r);
        #1;
        cyc++;
        if (io_cfg_done) begin n_done++; done_cyc = cyc; end
        check_all();
    endtask

    int t0, d0, a0;
    logic [CFG_W-1:0] snap;

    initial begin
        io_cfg_start = 0; io_cfg_valid = 0; io_cfg_sel = '0; reset = 1;
        model_step(0, 0, 0, 1);

        // Reset, then idle.
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);

        // Full load, word k = k mod 39, valid held.
        t0 = cyc; d0 = n_done;
        tick(1, 1, 0, 0);
        for (int k = 0; k < NUM_OUT + 4; k++) tick(0, 1, k % 39, 0);
        chk("s1_done_cycle", 512'(done_cyc - t0), 512'(56));
        chk("s1_done_count", 512'(n_done - d0), 512'(1));
        chk("s1_field0",  512'(io_mux_configs[5:0]),     512'(0));
        chk("s1_field53", 512'(io_mux_configs[323:318]), 512'(14));
        chk("s1_err",     512'(io_cfg_err), 512'(0));

        // Full load with word 10 out of range.
        tick(1, 0, 0, 0);
        for (int k = 0; k < NUM_OUT; k++) tick(0, 1, (k == 10) ? 45 : k % 39, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 7, 0);
        chk("s2_field10", 512'(io_mux_configs[65:60]), 512'(0));
        chk("s2_err", 512'(io_cfg_err), 512'(1));
        tick(1, 0, 0, 0);
        chk("s2_err_clr", 512'(io_cfg_err), 512'(0));
        tick(0, 0, 0, 0);

        // Abort after 20 words, then full reload.
        snap = io_mux_configs;
        for (int k = 0; k < 20; k++) tick(0, 1, 38 - k, 0);
        tick(1, 1, 5, 0);
        chk("s3_count", 512'(io_load_count), 512'(0));
        chk("s3_cfg_hold", 512'(io_mux_configs), 512'(snap));
        for (int k = 0; k < NUM_OUT + 2; k++) tick(0, 1, (k * 7) % 39, 0);
        chk("s3_new_field1", 512'(io_mux_configs[11:6]), 512'(7));

        // Valid toggling across a full load.
        d0 = n_done; a0 = n_acc;
        tick(1, 0, 0, 0);
        for (int k = 0; k < 2 * NUM_OUT + 6; k++) tick(0, (k % 2) == 0, $urandom_range(0, 38), 0);
        chk("s4_accepts", 512'(n_acc - a0), 512'(54));
        chk("s4_dones", 512'(n_done - d0), 512'(1));
        chk("s4_done_lat", 512'(done_cyc - last_acc), 512'(2));

        // Reset in cycle 30 of a load.
        d0 = n_done;
        tick(1, 0, 0, 0);
        for (int k = 1; k < 30; k++) tick(0, 1, k % 39, 0);
        tick(0, 1, 3, 1);
        chk("s5_busy", 512'(io_busy), 512'(0));
        chk("s5_cfg", 512'(io_mux_configs), 512'(0));
        for (int k = 0; k < 30; k++) tick(0, 1, k % 39, 0);
        chk("s5_no_done", 512'(n_done - d0), 512'(0));

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) < 7,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(39, 63)) : int'($urandom_range(0, 38)),
                 $urandom_range(0, 599) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
